stage5_ss4_encoder: RTL and testbench

STAGE5_SS4_ENCODER -- requirements
Module: stage5_SS4_encoder

---
 rtl/stage5_ss4_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_stage5_ss4_encoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage5_ss4_encoder.sv
// Three-lane SS4 field encoder: a round-robin arbiter feeds a 2-entry message FIFO.
// Optional macro SS4_SEQ_EN adds an 8-bit sequence number in message bits [7:0].
module stage5_ss4_encoder #(
  parameter int MSG_W   = 128,
  parameter int SS4_W   = 32,
  parameter int SS4_LSB = 64,
  parameter int CTRL_W  = 4,
  parameter logic [CTRL_W-1:0] Q_CODE = 4'h3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SS4_W-1:0]  SS4_in_1,
  input  logic [SS4_W-1:0]  SS4_in_2,
  input  logic [SS4_W-1:0]  SS4_in_3,
  input  logic              SS4_valid_1,
  input  logic              SS4_valid_2,
  input  logic              SS4_valid_3,
  output logic              SS4_ready_1,
  output logic              SS4_ready_2,
  output logic              SS4_ready_3,
  output logic [MSG_W-1:0]  message_out,
  output logic [CTRL_W-1:0] message_mux_control_out,
  output logic              message_en_out,
  input  logic              message_ready
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} fifo_state_t;

  fifo_state_t       state_r, state_nx_s;
  logic [MSG_W-1:0]  head_r, head_nx_s, tail_r, tail_nx_s;
  logic [CTRL_W-1:0] head_ctrl_r, head_ctrl_nx_s, tail_ctrl_r, tail_ctrl_nx_s;
  logic              en_r;
  logic [1:0]        last_r;
  logic [2:0]        valid_s, grant_s;
  logic [1:0]        grant_lane_s;
  logic [SS4_W-1:0]  grant_data_s;
  logic [7:0]        seq_s;
  logic [MSG_W-1:0]  new_msg_s;
  logic              push_s, pop_s;

  function automatic logic [MSG_W-1:0] build_msg(input logic [SS4_W-1:0] value,
                                                 input logic [1:0] lane,
                                                 input logic [7:0] seq);
    logic [MSG_W-1:0] m;
    m = '0;
    m[SS4_LSB +: SS4_W] = value;
    m[MSG_W-1 -: 2]     = lane;
    m[7:0]              = seq;
    return m;
  endfunction

  // Round-robin pick; last_r holds the index (0..2) of the last granted lane.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    case (last)
      2'd0: begin
        if (req[1]) g = 3'b010; else if (req[2]) g = 3'b100; else if (req[0]) g = 3'b001; else g = 3'b000;
      end
      2'd1: begin
        if (req[2]) g = 3'b100; else if (req[0]) g = 3'b001; else if (req[1]) g = 3'b010; else g = 3'b000;
      end
      default: begin
        if (req[0]) g = 3'b001; else if (req[1]) g = 3'b010; else if (req[2]) g = 3'b100; else g = 3'b000;
      end
    endcase
    return g;
  endfunction

  assign valid_s = {SS4_valid_3, SS4_valid_2, SS4_valid_1};

  // Grant lanes only when the FIFO has room; a pop in FULL never opens ready the same cycle.
  always_comb begin
    grant_s = 3'b000;
    if (!rst && state_r != FULL) begin
      grant_s = rr_pick(valid_s, last_r);
    end else begin
      grant_s = 3'b000;
    end
  end

  assign SS4_ready_1 = grant_s[0];
  assign SS4_ready_2 = grant_s[1];
  assign SS4_ready_3 = grant_s[2];
  assign push_s      = |grant_s;
  assign pop_s       = en_r & message_ready;

  // Selected lane payload and its 1-based index.
  always_comb begin
    grant_data_s = SS4_in_1;
    grant_lane_s = 2'd1;
    case (grant_s)
      3'b010: begin grant_data_s = SS4_in_2; grant_lane_s = 2'd2; end
      3'b100: begin grant_data_s = SS4_in_3; grant_lane_s = 2'd3; end
      default: begin grant_data_s = SS4_in_1; grant_lane_s = 2'd1; end
    endcase
  end

`ifdef SS4_SEQ_EN
  logic [7:0] seq_r;
  // Sequence number advances on every output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_r <= 8'd0;
    end else if (pop_s) begin
      seq_r <= seq_r + 8'd1;
    end else begin
      seq_r <= seq_r;
    end
  end
  assign seq_s = seq_r;
`else
  assign seq_s = 8'd0;
`endif

  assign new_msg_s = build_msg(grant_data_s, grant_lane_s, seq_s);

  // FIFO next-state: head entry drives the outputs and is zero whenever the FIFO is empty.
  always_comb begin
    state_nx_s     = state_r;
    head_nx_s      = head_r;
    head_ctrl_nx_s = head_ctrl_r;
    tail_nx_s      = tail_r;
    tail_ctrl_nx_s = tail_ctrl_r;
    case (state_r)
      EMPTY: begin
        if (push_s) begin
          head_nx_s      = new_msg_s;
          head_ctrl_nx_s = Q_CODE;
          state_nx_s     = ONE;
        end else begin
          state_nx_s = EMPTY;
        end
      end
      ONE: begin
        if (push_s && pop_s) begin
          head_nx_s      = new_msg_s;
          head_ctrl_nx_s = Q_CODE;
        end else if (push_s) begin
          tail_nx_s      = new_msg_s;
          tail_ctrl_nx_s = Q_CODE;
          state_nx_s     = FULL;
        end else if (pop_s) begin
          head_nx_s      = '0;
          head_ctrl_nx_s = '0;
          state_nx_s     = EMPTY;
        end else begin
          state_nx_s = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          head_nx_s      = tail_r;
          head_ctrl_nx_s = tail_ctrl_r;
          tail_nx_s      = '0;
          tail_ctrl_nx_s = '0;
          state_nx_s     = ONE;
        end else begin
          state_nx_s = FULL;
        end
      end
      default: begin
        head_nx_s      = '0;
        head_ctrl_nx_s = '0;
        tail_nx_s      = '0;
        tail_ctrl_nx_s = '0;
        state_nx_s     = EMPTY;
      end
    endcase
  end

  // State, storage and arbiter pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      head_r      <= '0;
      head_ctrl_r <= '0;
      tail_r      <= '0;
      tail_ctrl_r <= '0;
      en_r        <= 1'b0;
      last_r      <= 2'd2;
    end else begin
      state_r     <= state_nx_s;
      head_r      <= head_nx_s;
      head_ctrl_r <= head_ctrl_nx_s;
      tail_r      <= tail_nx_s;
      tail_ctrl_r <= tail_ctrl_nx_s;
      en_r        <= (state_nx_s != EMPTY);
      if (push_s) begin
        last_r <= grant_lane_s - 2'd1;
      end else begin
        last_r <= last_r;
      end
    end
  end

  assign message_out             = head_r;
  assign message_mux_control_out = head_ctrl_r;
  assign message_en_out          = en_r;

endmodule

// File: tb/tb_stage5_ss4_encoder.sv
// Self-checking bench for stage5_ss4_encoder: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbiter and message FIFO.
module tb_stage5_ss4_encoder;
  logic clk, rst;
  logic [31:0] in1, in2, in3;
  logic v1, v2, v3, r1, r2, r3;
  logic [127:0] msg;
  logic [3:0] ctrl;
  logic en, mready;

  int checks, failures;
  logic [127:0] mq[$];
  int mlast, mpops;

  stage5_ss4_encoder dut (
    .clk(clk), .rst(rst),
    .SS4_in_1(in1), .SS4_in_2(in2), .SS4_in_3(in3),
    .SS4_valid_1(v1), .SS4_valid_2(v2), .SS4_valid_3(v3),
    .SS4_ready_1(r1), .SS4_ready_2(r2), .SS4_ready_3(r3),
    .message_out(msg), .message_mux_control_out(ctrl),
    .message_en_out(en), .message_ready(mready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic lane_valid(input int l);
    if (l == 1) return v1;
    if (l == 2) return v2;
    return v3;
  endfunction

  function automatic logic [31:0] lane_data(input int l);
    if (l == 1) return in1;
    if (l == 2) return in2;
    return in3;
  endfunction

  function automatic logic [127:0] mk_msg(input int lane, input logic [31:0] v, input int seq);
    logic [127:0] m;
    m = 128'd0;
    m[95:64] = v;
    m[127:126] = lane[1:0];
`ifdef SS4_SEQ_EN
    m[7:0] = seq[7:0];
`endif
    return m;
  endfunction

  // Expected granted lane (0 = none): rotating priority from the lane after the last grant.
  function automatic int exp_grant();
    if (rst || mq.size() >= 2) return 0;
    for (int k = 1; k <= 3; k++) begin
      int l;
      l = ((mlast - 1 + k) % 3) + 1;
      if (lane_valid(l)) return l;
    end
    return 0;
  endfunction

  function automatic logic [2:0] onehot(input int l);
    logic [2:0] o;
    o = 3'b000;
    if (l != 0) o[l-1] = 1'b1;
    return o;
  endfunction

  function automatic logic [127:0] exp_msg();
    if (mq.size() == 0) return 128'd0;
    return mq[0];
  endfunction

  // Clock one edge and move the model along with it.
  task automatic advance();
    int g;
    logic pop;
    logic [127:0] nm;
    g = exp_grant();
    pop = (mq.size() > 0) && mready;
    nm = 128'd0;
    if (g != 0) nm = mk_msg(g, lane_data(g), mpops);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mlast = 3;
      mpops = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        mpops++;
      end
      if (g != 0) begin
        mq.push_back(nm);
        mlast = g;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1; mready = 1'b0;
    #2;
    checks++;
    if ({r3, r2, r1} !== 3'b000) begin failures++; $display("FAIL reset_ready: got %b expected 000", {r3, r2, r1}); end
    advance();
    checks++;
    if (en !== 1'b0 || msg !== 128'd0 || ctrl !== 4'd0) begin
      failures++; $display("FAIL reset_outputs: got en=%b msg=%h ctrl=%h expected all 0", en, msg, ctrl);
    end
    rst = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    mready = 1'b1; v1 = 1'b1; in1 = 32'hDEADBEEF;
    #2;
    checks++;
    if ({r3, r2, r1} !== 3'b001) begin failures++; $display("FAIL single_ready: got %b expected 001", {r3, r2, r1}); end
    advance();
    v1 = 1'b0;
    #2;
    checks++;
    if (en !== 1'b1 || msg[95:64] !== 32'hDEADBEEF || msg[127:126] !== 2'd1 || ctrl !== 4'h3 || msg[7:0] !== 8'd0) begin
      failures++; $display("FAIL single_msg: got en=%b msg=%h ctrl=%h expected en=1 field=deadbeef lane=1 ctrl=3", en, msg, ctrl);
    end
    advance();
    checks++;
    if (en !== 1'b0) begin failures++; $display("FAIL single_drain: got en=%b expected 0", en); end
  endtask

  task automatic test_round_robin();
    int order [6] = '{1, 2, 3, 1, 2, 3};
    do_reset();
    mready = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in1 = $urandom; in2 = $urandom; in3 = $urandom;
      #2;
      checks++;
      if ({r3, r2, r1} !== onehot(order[i])) begin
        failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, {r3, r2, r1}, onehot(order[i]));
      end
      advance();
    end
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    advance();
    advance();
  endtask

  task automatic test_backpressure();
    logic [31:0] d1, d2;
    logic [127:0] first, second;
    do_reset();
    mready = 1'b0; d1 = $urandom; d2 = $urandom;
    first = mk_msg(1, d1, 0); second = mk_msg(2, d2, 0);
    v1 = 1'b1; v2 = 1'b1; in1 = d1; in2 = d2;
    advance();
    advance();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({r3, r2, r1} !== 3'b000 || en !== 1'b1 || msg !== first || ctrl !== 4'h3) begin
        failures++; $display("FAIL bp_hold[%0d]: got rdy=%b en=%b msg=%h expected rdy=000 en=1 msg=%h", i, {r3, r2, r1}, en, msg, first);
      end
      advance();
    end
    v1 = 1'b0; v2 = 1'b0; mready = 1'b1;
    #2;
    checks++;
    if (msg !== first) begin failures++; $display("FAIL bp_drain1: got %h expected %h", msg, first); end
    advance();
    checks++;
    if (en !== 1'b1 || msg !== second) begin failures++; $display("FAIL bp_drain2: got en=%b msg=%h expected %h", en, msg, second); end
    advance();
    checks++;
    if (en !== 1'b0 || msg !== 128'd0) begin failures++; $display("FAIL bp_empty: got en=%b msg=%h expected 0", en, msg); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mready = 1'b0; v1 = 1'b1; v2 = 1'b1; in1 = $urandom; in2 = $urandom;
    advance();
    advance();
    v1 = 1'b0; v2 = 1'b0; rst = 1'b1;
    advance();
    rst = 1'b0;
    checks++;
    if (en !== 1'b0 || msg !== 128'd0 || ctrl !== 4'd0) begin
      failures++; $display("FAIL midrst_out: got en=%b msg=%h ctrl=%h expected all 0", en, msg, ctrl);
    end
    mready = 1'b1; v3 = 1'b1; in3 = 32'h0BADF00D;
    #2;
    checks++;
    if ({r3, r2, r1} !== 3'b100) begin failures++; $display("FAIL midrst_accept: got %b expected 100", {r3, r2, r1}); end
    advance();
    v3 = 1'b0;
    checks++;
    if (en !== 1'b1 || msg[95:64] !== 32'h0BADF00D || msg[127:126] !== 2'd3) begin
      failures++; $display("FAIL midrst_nostale: got en=%b msg=%h expected lane3 field 0badf00d", en, msg);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v1 = ($urandom_range(0, 9) < 6); v2 = ($urandom_range(0, 9) < 6); v3 = ($urandom_range(0, 9) < 6);
      in1 = $urandom; in2 = $urandom; in3 = $urandom;
      mready = ($urandom_range(0, 9) < 5);
      rst = ($urandom_range(0, 59) == 0);
      #2;
      checks++;
      if ({r3, r2, r1} !== onehot(exp_grant())) begin
        failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, {r3, r2, r1}, onehot(exp_grant()));
      end
      checks++;
      if (en !== (mq.size() > 0) || msg !== exp_msg() || ctrl !== ((mq.size() > 0) ? 4'h3 : 4'h0)) begin
        failures++; $display("FAIL rand_out[%0d]: got en=%b msg=%h ctrl=%h expected msg=%h", i, en, msg, ctrl, exp_msg());
      end
      advance();
    end
    rst = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
  endtask

`ifdef SS4_SEQ_EN
  task automatic test_seq_wrap();
    logic [7:0] want;
    do_reset();
    mready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      v1 = 1'b1; in1 = $urandom;
      advance();
      v1 = 1'b0;
      want = 8'(i % 256);
      checks++;
      if (en !== 1'b1 || msg[7:0] !== want) begin
        failures++; $display("FAIL seq[%0d]: got en=%b seq=%0d expected %0d", i, en, msg[7:0], want);
      end
      advance();
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0; mready = 1'b0;
    in1 = 32'd0; in2 = 32'd0; in3 = 32'd0;
    mlast = 3; mpops = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef SS4_SEQ_EN
    test_seq_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
